// File: rtl/nonce_sweeper.sv
// Mining control stage: loads a header template, target and start nonce, then
// sweeps nonces through an external double-SHA-256 hasher until a hit or range end.
module nonce_sweeper #(
    parameter int RANGE_BITS = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_valid,
    input  logic [7:0]   ld_data,
    output logic         ld_ready,
    input  logic         go,
    input  logic         abort,
    output logic         hash_rst_n,
    output logic         hash_start,
    output logic [639:0] hash_block,
    input  logic [255:0] hash_in,
    input  logic         hash_done,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic [31:0]  result_nonce
);

    typedef enum logic [2:0] {IDLE, LOAD, ARM, START, WAIT, CHECK} state_t;

    state_t                state_q, state_d;
    logic [607:0]          header_q, header_d;
    logic [255:0]          target_q, target_d;
    logic [31:0]           nonce_q, nonce_d;
    logic [31:0]           result_q, result_d;
    logic [RANGE_BITS-1:0] attempts_q, attempts_d;
    logic [6:0]            cnt_q, cnt_d;
    logic                  loaded_q, loaded_d;
    logic                  found_q, found_d;
    logic                  exhausted_q, exhausted_d;
    logic                  hash_rst_n_q, hash_rst_n_d;
    logic                  hash_start_q, hash_start_d;
    logic [255:0]          hash_le;
    logic                  load_byte;
    logic                  hit;

    // The hasher reports big-endian words; the difficulty compare wants the digest as a little-endian integer.
    always_comb begin
        hash_le = '0;
        for (int i = 0; i < 32; i++) begin
            hash_le[8*i +: 8] = hash_in[255-8*i -: 8];
        end
    end

    assign hit = (hash_le <= target_q);

    always_comb begin
        state_d     = state_q;
        header_d    = header_q;
        target_d    = target_q;
        nonce_d     = nonce_q;
        result_d    = result_q;
        attempts_d  = attempts_q;
        cnt_d       = cnt_q;
        loaded_d    = loaded_q;
        found_d     = found_q;
        exhausted_d = exhausted_q;
        load_byte   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ld_valid) begin
                    load_byte   = 1'b1;
                    state_d     = LOAD;
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
                    loaded_d    = 1'b0;
                end else if (go && loaded_q && !exhausted_q) begin
                    if (found_q) begin
                        nonce_d    = nonce_q + 32'd1;
                        attempts_d = attempts_q + RANGE_BITS'(1);
                    end
                    found_d = 1'b0;
                    state_d = ARM;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (ld_valid) begin
                    load_byte = 1'b1;
                end
            end
            ARM:   state_d = abort ? IDLE : START;
            START: state_d = abort ? IDLE : WAIT;
            WAIT: begin
                if (abort) state_d = IDLE;
                else if (hash_done) state_d = CHECK;
            end
            CHECK: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (hit) begin
                    found_d  = 1'b1;
                    result_d = nonce_q;
                    state_d  = IDLE;
                end else if (&attempts_q) begin
                    exhausted_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    nonce_d    = nonce_q + 32'd1;
                    attempts_d = attempts_q + RANGE_BITS'(1);
                    state_d    = ARM;
                end
            end
            default: state_d = IDLE;
        endcase

        // Each field is shifted in from the byte stream so its first byte lands in the right lane.
        if (load_byte) begin
            if (cnt_q < 7'd76) header_d = {header_q[599:0], ld_data};
            else if (cnt_q < 7'd108) target_d = {target_q[247:0], ld_data};
            else nonce_d = {ld_data, nonce_q[31:8]};
            if (cnt_q == 7'd111) begin
                cnt_d      = '0;
                loaded_d   = 1'b1;
                attempts_d = '0;
                state_d    = IDLE;
            end else begin
                cnt_d = cnt_q + 7'd1;
            end
        end

        hash_rst_n_d = (state_d == START) || (state_d == WAIT) || (state_d == CHECK);
        hash_start_d = (state_d == START);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            header_q     <= '0;
            target_q     <= '0;
            nonce_q      <= '0;
            result_q     <= '0;
            attempts_q   <= '0;
            cnt_q        <= '0;
            loaded_q     <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            hash_rst_n_q <= 1'b0;
            hash_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            header_q     <= header_d;
            target_q     <= target_d;
            nonce_q      <= nonce_d;
            result_q     <= result_d;
            attempts_q   <= attempts_d;
            cnt_q        <= cnt_d;
            loaded_q     <= loaded_d;
            found_q      <= found_d;
            exhausted_q  <= exhausted_d;
            hash_rst_n_q <= hash_rst_n_d;
            hash_start_q <= hash_start_d;
        end
    end

    assign ld_ready     = (state_q == IDLE) || (state_q == LOAD);
    assign busy         = (state_q == ARM) || (state_q == START) || (state_q == WAIT) || (state_q == CHECK);
    assign hash_block   = {header_q, nonce_q[7:0], nonce_q[15:8], nonce_q[23:16], nonce_q[31:24]};
    assign hash_rst_n   = hash_rst_n_q;
    assign hash_start   = hash_start_q;
    assign found        = found_q;
    assign exhausted    = exhausted_q;
    assign result_nonce = result_q;

endmodule

// File: tb/tb_nonce_sweeper.sv
// Self-checking bench for nonce_sweeper: hasher stub driven from a per-nonce hash
// table, with sweep outcomes predicted by scanning that table against the target.
module tb_nonce_sweeper;

    localparam int RB   = 3;
    localparam int NATT = 1 << RB;

    logic         clk = 1'b0;
    logic         rstN;
    logic         ldValid, go, abort;
    logic [7:0]   ldData;
    logic         ldReady, hashRstN, hashStart, busy, found, exhausted;
    logic [639:0] hashBlock;
    logic [255:0] hashInReg;
    logic         hashDoneReg;
    logic [31:0]  resultNonce;

    int total = 0;
    int bad   = 0;

    logic [7:0]   hdr [76];
    logic [255:0] tgtVal;
    logic [31:0]  baseNonce;
    logic [255:0] hashTable [16];
    logic [31:0]  startLog [$];
    int           stubCnt;
    logic         stubRun;

    nonce_sweeper #(.RANGE_BITS(RB)) dut (
        .clk(clk), .rst_n(rstN), .ld_valid(ldValid), .ld_data(ldData), .ld_ready(ldReady),
        .go(go), .abort(abort), .hash_rst_n(hashRstN), .hash_start(hashStart),
        .hash_block(hashBlock), .hash_in(hashInReg), .hash_done(hashDoneReg), .busy(busy),
        .found(found), .exhausted(exhausted), .result_nonce(resultNonce)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] nonceOf(input logic [639:0] blk);
        return {blk[7:0], blk[15:8], blk[23:16], blk[31:24]};
    endfunction

    function automatic logic [255:0] rev256(input logic [255:0] v);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = v[255-8*i -: 8];
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [3:0] tableIdx(input logic [31:0] n);
        logic [31:0] d;
        d = n - baseNonce;
        return d[3:0];
    endfunction

    // Hasher stub: result chosen by the nonce in the presented block, done a few cycles after start.
    always @(posedge clk) begin
        if (!hashRstN) begin
            hashDoneReg <= 1'b0;
            stubRun     <= 1'b0;
            stubCnt     <= 0;
        end else if (hashStart) begin
            stubRun   <= 1'b1;
            stubCnt   <= 0;
            hashInReg <= rev256(hashTable[tableIdx(nonceOf(hashBlock))]);
            startLog.push_back(nonceOf(hashBlock));
        end else if (stubRun) begin
            stubCnt <= stubCnt + 1;
            if (stubCnt == 3) hashDoneReg <= 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic g, input logic a);
        ldValid = v;
        ldData  = d;
        go      = g;
        abort   = a;
        @(negedge clk);
        ldValid = 1'b0;
        go      = 1'b0;
        abort   = 1'b0;
    endtask

    task automatic loadBytes(input int nBytes);
        logic [7:0] b;
        for (int k = 0; k < nBytes; k++) begin
            if (k < 76) b = hdr[k];
            else if (k < 108) b = tgtVal[255-8*(k-76) -: 8];
            else b = baseNonce[8*(k-108) +: 8];
            applyStimulus(1'b1, b, 1'b0, 1'b0);
        end
    endtask

    task automatic randomHeader();
        for (int k = 0; k < 76; k++) hdr[k] = 8'($urandom);
    endtask

    task automatic checkHeader(input string tag);
        logic [639:0] e;
        e = '0;
        for (int k = 0; k < 76; k++) e[639-8*k -: 8] = hdr[k];
        checkOutput(tag, {hashBlock[639:32], 32'h0}, e);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        logic foundEarly = 1'b0;
        while (busy === 1'b1 && n < budget) begin
            if (found !== 1'b0) foundEarly = 1'b1;
            @(negedge clk);
            n++;
        end
        checkOutput("sweep_timeout", n < budget, 1'b1);
        checkOutput("found_while_busy", foundEarly, 1'b0);
    endtask

    // Predicts the outcome by scanning attempts fromIdx..NATT-1 for the first hash at or below target.
    task automatic runSweep(input string tag, input int fromIdx);
        int hitIdx = -1;
        int lastIdx;
        int wrong = 0;
        for (int i = fromIdx; i < NATT; i++) begin
            if (hashTable[i] <= tgtVal) begin
                hitIdx = i;
                break;
            end
        end
        lastIdx = (hitIdx < 0) ? NATT - 1 : hitIdx;
        startLog.delete();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput({tag, "_arm_rst"}, hashRstN, 1'b0);
        checkOutput({tag, "_arm_start"}, hashStart, 1'b0);
        checkOutput({tag, "_arm_busy"}, busy, 1'b1);
        checkOutput({tag, "_go_clears_found"}, found, 1'b0);
        @(negedge clk);
        checkOutput({tag, "_start_pulse"}, {hashStart, hashRstN}, 2'b11);
        checkOutput({tag, "_first_nonce"}, nonceOf(hashBlock), baseNonce + 32'(fromIdx));
        waitIdle(400);
        checkOutput({tag, "_found"}, found, hitIdx >= 0);
        checkOutput({tag, "_exhausted"}, exhausted, hitIdx < 0);
        if (hitIdx >= 0) checkOutput({tag, "_result"}, resultNonce, baseNonce + 32'(hitIdx));
        checkOutput({tag, "_starts"}, startLog.size(), lastIdx - fromIdx + 1);
        for (int j = 0; j < startLog.size(); j++)
            if (startLog[j] !== baseNonce + 32'(fromIdx + j)) wrong++;
        checkOutput({tag, "_nonce_seq"}, wrong, 0);
    endtask

    initial begin
        rstN = 1'b0; ldValid = 1'b0; ldData = 8'h00; go = 1'b0; abort = 1'b0;
        baseNonce = '0; tgtVal = '0;
        for (int i = 0; i < 16; i++) hashTable[i] = '1;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", {ldReady, hashRstN, hashStart, busy, found, exhausted}, 6'b100000);
        checkOutput("reset_block", hashBlock, '0);
        checkOutput("reset_result", resultNonce, 32'h0);
        rstN = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("go_unloaded", {busy, hashStart}, 2'b00);

        // Load and first hit: header 0x00..0x4B, target all ones.
        for (int k = 0; k < 76; k++) hdr[k] = 8'(k);
        tgtVal = '1;
        baseNonce = 32'h12345678;
        for (int i = 0; i < 16; i++) hashTable[i] = rand256();
        loadBytes(112);
        checkOutput("nonce_field", hashBlock[31:0], 32'h78563412);
        checkOutput("hdr_byte0", hashBlock[639:632], 8'h00);
        checkHeader("hdr_first");
        runSweep("first", 0);
        checkOutput("first_result_const", resultNonce, 32'h12345678);

        // Hit on fourth nonce, then resume until the range runs out.
        randomHeader();
        tgtVal = 256'd1 << 200;
        baseNonce = $urandom;
        for (int i = 0; i < 16; i++) hashTable[i] = rand256() | (256'd1 << 255);
        hashTable[3] = rand256() & ((256'd1 << 200) - 256'd1);
        loadBytes(112);
        checkHeader("hdr_fourth");
        runSweep("fourth", 0);
        runSweep("resume", 4);

        // Exhaustion with 32-bit wrap.
        randomHeader();
        tgtVal = '0;
        baseNonce = 32'hFFFFFFFE;
        for (int i = 0; i < 16; i++) hashTable[i] = rand256() | 256'd1;
        loadBytes(112);
        runSweep("wrap", 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("go_after_exhaust", {busy, hashStart, exhausted}, 3'b001);

        // Randomized sweeps.
        for (int it = 0; it < 5; it++) begin
            randomHeader();
            tgtVal = rand256() >> $urandom_range(0, 64);
            baseNonce = $urandom;
            for (int i = 0; i < 16; i++)
                hashTable[i] = ($urandom_range(0, 3) == 0) ? (tgtVal >> $urandom_range(0, 4))
                                                          : (rand256() | (256'd1 << 255));
            loadBytes(112);
            checkHeader("hdr_rand");
            runSweep("rand", 0);
        end

        // Abort while waiting on the hasher.
        randomHeader();
        tgtVal = '1;
        baseNonce = $urandom;
        loadBytes(112);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("abort_wait", {busy, hashRstN, found, hashStart}, 4'b0000);

        // Partial load then go: the go is ignored while loading.
        loadBytes(50);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("partial_go", {busy, hashStart}, 2'b00);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a WAIT.
        loadBytes(112);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("pre_reset_busy", busy, 1'b1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("async_reset_ctl", {ldReady, hashRstN, hashStart, busy, found, exhausted}, 6'b100000);
        checkOutput("async_reset_block", hashBlock, '0);
        checkOutput("async_reset_result", resultNonce, 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("go_after_reset", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
